// File: rtl/hack_mul_seq.sv
// hack_mul_seq: multi-cycle 16-bit shift-and-add multiplier built around a
// single Hack ALU. Each multiplier bit costs two cycles: ADD (conditional
// accumulate) then DBL (double the multiplicand). A start/busy/done handshake
// lets it sit beside the Hack CPU as a coprocessor.
//
// Build option: define HACK_MUL_EARLY_EXIT_EN to leave the loop as soon as the
// remaining multiplier bits are all zero (latency 2*k, k = max(1, msb(b)+1)).
// Without it every operation takes a fixed 32 cycles. The product is the same.

// Hack ALU: zero/negate each input, add or AND, optionally negate the result.
module alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);
    logic [WIDTH-1:0] x_z, x_n, y_z, y_n, f_out;

    // Input conditioning, function select and output negation.
    always_comb begin
        x_z   = zx ? '0 : x;
        x_n   = nx ? ~x_z : x_z;
        y_z   = zy ? '0 : y;
        y_n   = ny ? ~y_z : y_z;
        f_out = f ? (x_n + y_n) : (x_n & y_n);
        out   = no ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[WIDTH-1];
    end
endmodule

module hack_mul_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zr,
    output logic             ng
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DBL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_next;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [4:0]       cnt;

    logic [WIDTH-1:0] alu_x, alu_out;
    logic             alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
    logic             alu_zr_unused, alu_ng_unused;
    logic             x_from_mcand;
    logic             accept;
    logic             last_iter;

    alu #(.WIDTH(WIDTH)) u_alu (
        .x   (alu_x),
        .y   (mcand),
        .zx  (alu_zx),
        .nx  (alu_nx),
        .zy  (alu_zy),
        .ny  (alu_ny),
        .f   (alu_f),
        .no  (alu_no),
        .out (alu_out),
        .zr  (alu_zr_unused),
        .ng  (alu_ng_unused)
    );

    // Loop exit test and start acceptance (IDLE, or back-to-back from DONE).
    always_comb begin
`ifdef HACK_MUL_EARLY_EXIT_EN
        last_iter = (cnt == 5'd15) || (mplier[WIDTH-1:1] == '0);
`else
        last_iter = (cnt == 5'd15);
`endif
        accept = start && ((state == IDLE) || (state == DONE));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ADD;
            ADD:     state_next = DBL;
            DBL:     state_next = last_iter ? DONE : ADD;
            DONE:    state_next = start ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs and ALU control: x+y while iterating, constant 0 otherwise.
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        x_from_mcand = 1'b0;
        {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b101010;
        case (state)
            ADD: begin
                busy = 1'b1;
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000010;
            end
            DBL: begin
                busy         = 1'b1;
                x_from_mcand = 1'b1;
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b000010;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
        alu_x = x_from_mcand ? mcand : acc;
    end

    // Datapath registers; product is loaded on the DBL->DONE edge so it is
    // already valid during the done cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            if (accept) begin
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= '0;
            end else if (state == ADD) begin
                if (mplier[0]) acc <= alu_out;
            end else if (state == DBL) begin
                mcand  <= alu_out;
                mplier <= mplier >> 1;
                cnt    <= cnt + 5'd1;
                if (last_iter) product <= acc;
            end
        end
    end

    // Status flags follow the held product.
    always_comb begin
        zr = (product == '0);
        ng = product[WIDTH-1];
    end
endmodule

// File: tb/tb_hack_mul_seq.sv
// Self-checking bench for hack_mul_seq: expected products and latencies are
// queued when an operation is accepted and compared when done pulses.
module tb_hack_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, zr, ng;
    logic [15:0] product;

    typedef struct {
        logic [15:0] prod;
        int          t0;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic prev_done = 1'b0;

    hack_mul_seq #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int exp_k(input logic [15:0] mb);
        int k;
`ifdef HACK_MUL_EARLY_EXIT_EN
        k = 1;
        for (int i = 0; i < 16; i++) if (mb[i]) k = i + 1;
`else
        k = 16;
`endif
        return k;
    endfunction

    // Assumes the caller is at a negedge; start is sampled at the next posedge.
    task automatic launch(input logic [15:0] ia, input logic [15:0] ib, input bit track);
        exp_t ne;
        start = 1'b1;
        a     = ia;
        b     = ib;
        @(posedge clk);
        #1;
        if (track) begin
            ne.prod = ia * ib;
            ne.t0   = cyc;
            ne.lat  = 2 * exp_k(ib);
            q.push_back(ne);
        end
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    task automatic do_start(input logic [15:0] ia, input logic [15:0] ib, input bit track);
        @(negedge clk);
        launch(ia, ib, track);
    endtask

    // Returns at the negedge where done is seen high.
    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 100);
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    // Scoreboard: compare every done pulse against the oldest queued result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                check("done_busy", {31'd0, busy}, 32'd0);
                check("done_pulse", {31'd0, prev_done}, 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("product", {16'd0, product}, {16'd0, e.prod});
                    check("zr", {31'd0, zr}, {31'd0, (e.prod == 16'd0)});
                    check("ng", {31'd0, ng}, {31'd0, e.prod[15]});
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end else if (q.size() > 0) begin
                check("busy_in_flight", {31'd0, busy}, 32'd1);
            end
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        check("rst_zr", {31'd0, zr}, 32'd1);
        check("rst_ng", {31'd0, ng}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic, zero, sign, wrap and full-width operands.
        do_start(16'd3, 16'd5, 1'b1);        wait_done();
        do_start(16'h1234, 16'h0000, 1'b1);  wait_done();
        do_start(16'hFFFD, 16'd5, 1'b1);     wait_done();
        do_start(16'h0100, 16'h0100, 1'b1);  wait_done();
        do_start(16'h0011, 16'hFFFF, 1'b1);  wait_done();
        do_start(16'd3, 16'd5, 1'b1);        wait_done();

        // Asynchronous reset mid-operation clears everything without a clock.
        do_start(16'd3, 16'd5, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_product", {16'd0, product}, 32'd0);
        check("midrst_zr", {31'd0, zr}, 32'd1);
        check("midrst_ng", {31'd0, ng}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_done = 1'b0;
        do_start(16'd2, 16'd2, 1'b1);        wait_done();

        // Start pulses and operand changes while busy are ignored.
        do_start(16'd7, 16'd9, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        a     = 16'd2;
        b     = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Start in the done cycle is accepted back-to-back.
        launch(16'd2, 16'd3, 1'b1);
        wait_done();

        // A few random operands.
        for (int i = 0; i < 6; i++) begin
            do_start(16'($urandom), 16'($urandom), 1'b1);
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hack_mul_seq.md
Name: hack_mul_seq

Overview:
- Multi-cycle 16-bit multiplier built around one instance of the existing Hack `alu` (ports x, y, zx, nx, zy, ny, f, no, out, zr, ng).
- Sequences the ALU through shift-and-add: conditional accumulate, then double the multiplicand, once per multiplier bit.
- Sits beside the Hack CPU as a coprocessor, with a start/busy/done handshake and a result register.

Parameters:
- WIDTH, 16, datapath width; must equal the `alu` width; only 16 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled at the rising edge of clk.
- a  input  16  multiplicand; captured when start is accepted.
- b  input  16  multiplier; captured when start is accepted.
- busy  output  1  high while the operation is in progress (states ADD, DBL).
- done  output  1  high for exactly one cycle when product is valid.
- product  output  16  low 16 bits of a*b (two's complement, wraps mod 2^16); held until the next completion.
- zr  output  1  product == 0.
- ng  output  1  product[15].

Behaviour:
- Reset: rst_n low forces the following, asynchronously and including mid-operation:
  - state IDLE;
  - busy=0, done=0, product=0, zr=1, ng=0;
  - internal acc/mcand/mplier/cnt cleared.
- Internal registers:
  - acc[15:0], mcand[15:0], mplier[15:0], cnt[4:0].
  - ALU x/y are muxed from acc/mcand.
- ALU control codes:
  - ADD and DBL states drive zx,nx,zy,ny,f,no = 0,0,0,0,1,0 (x+y).
  - IDLE and DONE drive 1,0,1,0,1,0 (constant 0).
- IDLE:
  - If start=1: acc<=0, mcand<=a, mplier<=b, cnt<=0, go to ADD.
  - Otherwise stay.
- ADD (1 cycle):
  - x=acc, y=mcand.
  - If mplier[0]=1, acc<=alu.out; else acc unchanged.
  - Go to DBL.
- DBL (1 cycle):
  - x=y=mcand; mcand<=alu.out; mplier<=mplier>>1; cnt<=cnt+1.
  - If cnt==15, go to DONE; else go to ADD.
- DONE (1 cycle):
  - product<=acc (registered on entry, so valid while done=1); zr/ng update with product.
  - done=1, busy=0.
  - If start=1 in this cycle, it is accepted exactly as in IDLE (next state ADD); otherwise go to IDLE.
- start while busy=1: ignored, with no effect on the operation in flight.
- a/b changes after acceptance: no effect.
- Latency: start sampled at edge N, done high after edge N+2k, where k is the number of bit iterations.
  - Base build: k=16 (32 cycles).
  - With the optional feature: see below.
- Overflow: silently wraps, matching the ALU adder; no carry or overflow output.
- Signed operands: correct low 16 bits with no special handling.

Optional Feature:
- HACK_MUL_EARLY_EXIT_EN defined:
  - DBL also exits to DONE when (mplier>>1)==0.
  - k = max(1, index of highest set bit of b + 1), so latency is 2k cycles: b=0 gives 2, b=5 gives 6, b=0x8000 gives 32.
- Undefined: fixed 32-cycle latency for every operand.
- The product is identical either way.

Test Plan:
- Reset mid-run: start a=3, b=5, pull rst_n low after 3 cycles -> busy=0, done=0, product=0, zr=1 immediately (no clock needed); after release a new start a=2, b=2 -> product=4, zr=0, ng=0.
- Basic: a=3, b=5 -> done after 32 cycles (base) / 6 cycles (HACK_MUL_EARLY_EXIT_EN); product=0x000F, zr=0, ng=0; done high exactly one cycle.
- Zero and sign: a=0x1234, b=0 -> product=0x0000, zr=1 (latency 32 / 2). a=0xFFFD (-3), b=5 -> product=0xFFF1, ng=1.
- Wrap and full width: a=0x0100, b=0x0100 -> product=0x0000, zr=1. a=0x0011, b=0xFFFF (-1) -> product=0xFFEF, ng=1, latency 32 in both builds.
- Handshake: pulse start with a=7, b=9 while busy=1 -> ignored, result stays 63 (0x003F). Assert start with a=2, b=3 in the done cycle -> accepted back-to-back; next done gives product=6; busy never drops except during the DONE cycle.
